// File: rtl/clk_div_multi.sv
// Multi-channel clock divider: NUM_CH independent 50%-duty divided clocks with rise-aligned ticks.
// Divisor and enable updates are applied only at toggle points so outputs never glitch.
module clk_div_multi #(
  parameter int NUM_CH            = 4,
  parameter int WIDTH_DIV         = 16,
  parameter int WIDTH_CONFIG_ADDR = 8,
  parameter int WIDTH_CONFIG_DATA = 16,
  parameter int DEFAULT_DIV       = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  input  logic [WIDTH_CONFIG_DATA-1:0] c_data,
  input  logic                         c_valid,
  output logic                         c_ready,
  output logic [NUM_CH-1:0]            clk_out,
  output logic [NUM_CH-1:0]            tick
);

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } cfg_state_e;

  localparam logic [WIDTH_DIV-1:0]         DEF_DIV   = WIDTH_DIV'(DEFAULT_DIV);
  localparam logic [WIDTH_DIV-1:0]         ONE_DIV   = WIDTH_DIV'(1);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] MASK_ADDR = WIDTH_CONFIG_ADDR'(NUM_CH);

  cfg_state_e state_q, state_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] o_q, o_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [WIDTH_DIV-1:0] cnt_q [NUM_CH];
  logic [WIDTH_DIV-1:0] cnt_d [NUM_CH];
  logic [WIDTH_DIV-1:0] div_q [NUM_CH];
  logic [WIDTH_DIV-1:0] div_d [NUM_CH];
  logic [WIDTH_DIV-1:0] shd_q [NUM_CH];
  logic [WIDTH_DIV-1:0] shd_d [NUM_CH];

  logic                 accept;
  logic [WIDTH_DIV-1:0] wr_raw;
  logic [WIDTH_DIV-1:0] wr_div;
  logic [NUM_CH-1:0]    run;
  logic [NUM_CH-1:0]    wrap;

  generate
    if (WIDTH_CONFIG_DATA >= WIDTH_DIV) begin : g_div_trunc
      assign wr_raw = c_data[WIDTH_DIV-1:0];
    end else begin : g_div_zext
      assign wr_raw = {{(WIDTH_DIV-WIDTH_CONFIG_DATA){1'b0}}, c_data};
    end
  endgenerate

  assign wr_div = (wr_raw == '0) ? ONE_DIV : wr_raw;

  // Handshake: a write transfers on a rising edge where c_valid && c_ready are both high;
  // the target register takes the value on that same edge and c_ready drops for one cycle.
  assign c_ready = (state_q == IDLE);
  assign accept  = c_valid && c_ready;

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    for (int i = 0; i < NUM_CH; i++) begin
      shd_d[i] = shd_q[i];
    end
    case (state_q)
      IDLE:    if (accept) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      if (c_addr == MASK_ADDR) begin
        en_d = c_data[NUM_CH-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (c_addr == WIDTH_CONFIG_ADDR'(i)) begin
          shd_d[i] = wr_div;
        end
      end
    end
  end

  // A disabled channel that is still high keeps running until it falls, so highs are never cut short.
  always_comb begin
    o_d    = o_q;
    tick_d = '0;
    run    = '0;
    wrap   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      div_d[i] = div_q[i];
      run[i]   = en_q[i] | o_q[i];
      wrap[i]  = (cnt_q[i] == (div_q[i] - ONE_DIV));
      if (run[i]) begin
        if (wrap[i]) begin
          cnt_d[i]  = '0;
          o_d[i]    = ~o_q[i];
          div_d[i]  = shd_q[i];
          tick_d[i] = ~o_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + ONE_DIV;
        end
      end else begin
        cnt_d[i] = '0;
        o_d[i]   = 1'b0;
        div_d[i] = shd_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= '1;
      o_q     <= '0;
      tick_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DEF_DIV;
        shd_q[i] <= DEF_DIV;
      end
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      o_q     <= o_d;
      tick_q  <= tick_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
        shd_q[i] <= shd_d[i];
      end
    end
  end

  assign clk_out = o_q;
  assign tick    = tick_q;

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider, the next generation of the fixed four-output CD block. It generates NUM_CH independent divided clocks (square waves) plus matching single-cycle tick strobes from one system clock. Divisors and the channel-enable mask are programmed at run time over the standard config handshake. Divisor changes and disables take effect only at safe toggle points, so outputs never glitch.

## Interface
- NUM_CH, 4: number of divided-clock channels (1..16)
- WIDTH_DIV, 16: width of each divisor register
- WIDTH_CONFIG_ADDR, 8: config address width
- WIDTH_CONFIG_DATA, 16: config data width
- DEFAULT_DIV, 2: divisor loaded into every channel at reset (must be >= 1)

Ports:
- clk  in  1  system clock; single clock domain, all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- c_addr  in  WIDTH_CONFIG_ADDR  config register address
- c_data  in  WIDTH_CONFIG_DATA  config write data
- c_valid  in  1  config write request
- c_ready  out  1  block can accept a config write
- clk_out  out  NUM_CH  divided clocks, one bit per channel, registered
- tick  out  NUM_CH  one-cycle strobe in the cycle the matching clk_out bit rises

## Operation
- Address map:
  - Addresses 0..NUM_CH-1 write the shadow divisor of that channel.
  - Address NUM_CH writes the enable mask from c_data[NUM_CH-1:0].
  - Any other address is accepted and ignored.
- Data width rule: the divisor takes c_data[WIDTH_DIV-1:0] when WIDTH_CONFIG_DATA >= WIDTH_DIV; otherwise c_data is zero-extended. A written divisor of 0 is stored as 1.
- Config FSM has two states, IDLE and APPLY:
  - IDLE: c_ready=1. A write is accepted when c_valid && c_ready. The shadow or mask register updates on the next edge and the FSM moves to APPLY.
  - APPLY: c_ready=0, no write is accepted. The FSM returns to IDLE after one cycle.
- Per-channel state: counter cnt, active divisor D, shadow divisor S, output bit o.
- Enabled channel:
  - cnt counts 0..D-1.
  - At cnt==D-1: o toggles, cnt returns to 0, and D takes the value of S. D therefore updates only at toggle points.
  - Output period is 2·D system cycles at 50% duty.
- Disable (mask bit 1->0):
  - If o=0: the channel stops immediately, cnt is held at 0.
  - If o=1: the channel keeps running until its next toggle (o falls), then stops.
  - No shortened high pulse is ever produced.
- Disabled channel: o=0 and cnt=0. D follows S every cycle.
- Enable (mask bit 0->1): counting starts from cnt=0 on the following cycle. The first rising edge comes D cycles after the mask update.
- tick[i]=1 exactly in the cycles where clk_out[i] goes 0->1, aligned with that edge. It is never asserted for a disabled channel.

## Timing
- Reset values:
  - clk_out=0, tick=0, c_ready=1, FSM=IDLE
  - all cnt=0, all D=S=DEFAULT_DIV, enable mask all ones
- All channels start running straight out of reset. The first rise of every channel is DEFAULT_DIV cycles after rst_n deasserts.
- Write accepted at edge T: the register is updated at T+1, c_ready is 0 during cycle T+1, and c_ready is 1 again at T+2. Maximum write rate is one write per 2 cycles.
- Divisor written while the channel is running: the new D is used starting at the first toggle point at or after T+1. If the old count reaches D-1 exactly in cycle T, the old S is loaded there, and the new value takes effect at the following toggle.
- Mask write and divisor write to the same channel in consecutive accepted writes: the divisor lands in S. If the channel is disabled at that point, D follows S immediately.
- Channels are fully independent. Simultaneous toggles on all channels are legal.
- Reset asserted mid-operation: all outputs clear asynchronously, and any half-completed config write is discarded.
- Output latency: clk_out and tick are flop outputs with no combinational path from the inputs.

## Test plan
- Reset release with DEFAULT_DIV=2: all clk_out bits toggle every 2 cycles (period 4). First rise at cycle 2 after reset, with tick[i]=1 in the same cycle only.
- Write addr 1, data 5 while ch1 runs at D=2: c_ready drops for one cycle. ch1 finishes its current half-period at D=2, then shows period 10. No half-period of other than 2 or 5 cycles appears.
- Write addr NUM_CH, data 4'b1110 while clk_out[0]=1: ch0 stays high until its normal toggle, then holds 0. tick[0] stays 0 thereafter, and ch1-3 are unaffected.
- Write ch2 divisor 0 while disabled, then enable: ch2 runs with D=1 (period 2). The first rise comes 1 cycle after the mask update.
- Back-to-back c_valid held high for 4 cycles with different addresses: only writes in cycles where c_ready=1 are taken (every other cycle). Writes to address 200 are acknowledged but change nothing.
- Assert rst_n low mid-APPLY and mid-high-phase: clk_out, tick → 0 immediately; after release, c_ready=1 and all channels return to period 2·DEFAULT_DIV.
